// File: rtl/bl_mux_ctrl.sv
// bl_mux_ctrl: registered control front-end for an 8:1 analog bit-line multiplexer
// (ADG1408 class).
//
// The enable and the 3-bit address requests arrive asynchronously. Each one passes through a
// 2-flop synchronizer. A small FSM then drives the mux EN and A2..A0 pins with two guard
// intervals:
//   - address setup:    A*_out settles for SETUP_CYCLES clocks before EN_out rises.
//   - break-before-make: EN_out stays low for BREAK_CYCLES clocks before a new address is
//                        driven while the channel is live.
// The address pins never move while EN_out is high, or on the edge where EN_out rises.
// Every output comes straight from a flop.
//
// Optional feature macro: BL_MUX_CH_STATUS_EN
//   When defined, a registered one-hot channel status output ch_active[7:0] is added.
//   It decodes {A2_out,A1_out,A0_out} while EN_out is high and reads all zeros otherwise.

module bl_mux_ctrl #(
   parameter int unsigned SETUP_CYCLES = 4,
   parameter int unsigned BREAK_CYCLES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       EN_in,
   input  logic       A2_in,
   input  logic       A1_in,
   input  logic       A0_in,
   output logic       A2_out,
   output logic       A1_out,
   output logic       A0_out,
   output logic       EN_out
`ifdef BL_MUX_CH_STATUS_EN
   ,
   output logic [7:0] ch_active
`endif
);

   // Reject guard intervals that the 16-bit counter cannot represent.
   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 65535) begin : g_bad_setup
      $error("bl_mux_ctrl: SETUP_CYCLES out of range 1..65535");
   end
   if (BREAK_CYCLES < 1 || BREAK_CYCLES > 65535) begin : g_bad_break
      $error("bl_mux_ctrl: BREAK_CYCLES out of range 1..65535");
   end

   // The counter is loaded with N-1 and expires when it reads zero.
   // That places the action exactly N edges after the load edge.
   localparam logic [15:0] SetupLoad = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] BreakLoad = 16'(BREAK_CYCLES - 1);

   // FSM encoding
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StSetup = 2'd1;
   localparam logic [1:0] StOn    = 2'd2;
   localparam logic [1:0] StBreak = 2'd3;

   // ---------------------------------------------------------------------------------------
   // Input synchronizers: bit 3 is the enable, bits 2..0 are the address.
   // ---------------------------------------------------------------------------------------
   logic [3:0] req_raw;
   logic [3:0] meta_q;
   logic [3:0] sync_q;
   logic       en_s;
   logic [2:0] addr_s;

   assign req_raw = {EN_in, A2_in, A1_in, A0_in};
   assign en_s    = sync_q[3];
   assign addr_s  = sync_q[2:0];

   // Two-stage synchronizer for all four request bits, cleared by reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= req_raw;
         sync_q <= meta_q;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Control FSM, guard counter and output registers
   // ---------------------------------------------------------------------------------------
   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  addr_q, addr_d;
   logic        en_q, en_d;
   logic        cnt_zero;
   logic        addr_diff;

   assign cnt_zero  = (cnt_q == 16'd0);
   assign addr_diff = (addr_s != addr_q);

   // Next-state logic. A dropped enable always beats an address change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      en_d    = en_q;

      case (state_q)
         StIdle: begin
            en_d = 1'b0;
            if (en_s) begin
               addr_d  = addr_s;
               cnt_d   = SetupLoad;
               state_d = StSetup;
            end
         end

         StSetup: begin
            en_d = 1'b0;
            if (!en_s) begin
               state_d = StIdle;
            end else if (addr_diff) begin
               // Channel is not live yet: follow the request and restart the setup time.
               addr_d = addr_s;
               cnt_d  = SetupLoad;
            end else if (cnt_zero) begin
               en_d    = 1'b1;
               state_d = StOn;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         StOn: begin
            en_d = 1'b1;
            if (!en_s) begin
               en_d    = 1'b0;
               state_d = StIdle;
            end else if (addr_diff) begin
               // Open the switch first. The address is held until the break time expires.
               en_d    = 1'b0;
               cnt_d   = BreakLoad;
               state_d = StBreak;
            end
         end

         StBreak: begin
            en_d = 1'b0;
            if (!en_s) begin
               state_d = StIdle;
            end else if (cnt_zero) begin
               // Take the newest request, not the one that started the break.
               addr_d  = addr_s;
               cnt_d   = SetupLoad;
               state_d = StSetup;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         default: begin
            en_d    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State, counter and pin registers. Reset clears everything asynchronously.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
      end
   end

   assign A2_out = addr_q[2];
   assign A1_out = addr_q[1];
   assign A0_out = addr_q[0];
   assign EN_out = en_q;

`ifdef BL_MUX_CH_STATUS_EN
   // ---------------------------------------------------------------------------------------
   // Channel status: a one-hot decode built from next-state values.
   // This makes it change on the same edge as EN_out.
   // ---------------------------------------------------------------------------------------
   logic [7:0] ch_active_q, ch_active_d;

   // Decode the live channel. Reads zero while the switch is open.
   always_comb begin
      ch_active_d = 8'd0;
      if (en_d) begin
         ch_active_d = 8'd1 << addr_d;
      end
   end

   // Status register, cleared by reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ch_active_q <= '0;
      end else begin
         ch_active_q <= ch_active_d;
      end
   end

   assign ch_active = ch_active_q;
`endif

endmodule

// File: tb/tb_bl_mux_ctrl.sv
// tb_bl_mux_ctrl: directed self-checking bench for bl_mux_ctrl.
// It uses SETUP_CYCLES=4 and BREAK_CYCLES=2.
// Inputs change, and outputs are sampled, 1 time unit after each rising edge.

module tb_bl_mux_ctrl;

   logic Clk = 1'b0;
   logic Reset;
   logic EN_in, A2_in, A1_in, A0_in;
   logic A2_out, A1_out, A0_out, EN_out;
`ifdef BL_MUX_CH_STATUS_EN
   logic [7:0] ch_active;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   bl_mux_ctrl #(
      .SETUP_CYCLES(4),
      .BREAK_CYCLES(2)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .EN_in (EN_in),
      .A2_in (A2_in),
      .A1_in (A1_in),
      .A0_in (A0_in),
      .A2_out(A2_out),
      .A1_out(A1_out),
      .A0_out(A0_out),
      .EN_out(EN_out)
`ifdef BL_MUX_CH_STATUS_EN
      ,
      .ch_active(ch_active)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic set_addr(input logic [2:0] a);
      {A2_in, A1_in, A0_in} = a;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Checks EN_out and the address pins together.
   task automatic check_pins(input string tag, input logic en, input logic [2:0] a);
      check({tag, " EN_out"}, {7'd0, EN_out}, {7'd0, en});
      check({tag, " A_out"}, {5'd0, A2_out, A1_out, A0_out}, {5'd0, a});
   endtask

   initial begin
      logic [2:0] prev;
      Reset = 1'b0;
      EN_in = 1'b0;
      set_addr(3'b000);

      // 1. Reset held low with the inputs toggling.
      tick(1);
      EN_in = 1'b1; set_addr(3'b111);
      tick(3);
      check_pins("reset_toggle_a", 1'b0, 3'b000);
      EN_in = 1'b0; set_addr(3'b010);
      tick(3);
      check_pins("reset_toggle_b", 1'b0, 3'b000);
      set_addr(3'b000);
      tick(2);
      Reset = 1'b1;
      tick(5);
      check_pins("release_idle", 1'b0, 3'b000);

      // 2. Address 101, then raise the enable.
      set_addr(3'b101);
      tick(3);
      EN_in = 1'b1;
      tick(2);
      check_pins("en_rise_t2", 1'b0, 3'b000);
      tick(1);
      check_pins("en_rise_t3", 1'b0, 3'b101);
      tick(3);
      check_pins("setup_t6", 1'b0, 3'b101);
      tick(1);
      check_pins("setup_t7", 1'b1, 3'b101);

      // 3. Drop the enable while ON.
      EN_in = 1'b0;
      tick(2);
      check_pins("drop_t2", 1'b1, 3'b101);
      tick(1);
      check_pins("drop_t3", 1'b0, 3'b101);
      tick(4);
      check_pins("drop_idle", 1'b0, 3'b101);

      // 4. ON at 000, then switch to 111 through the break interval.
      set_addr(3'b000);
      EN_in = 1'b1;
      tick(7);
      check_pins("on_000", 1'b1, 3'b000);
      set_addr(3'b111);
      tick(3);
      check_pins("brk_t3", 1'b0, 3'b000);
      tick(1);
      check_pins("brk_t4", 1'b0, 3'b000);
      tick(1);
      check_pins("brk_t5", 1'b0, 3'b111);
      tick(3);
      check_pins("brk_t8", 1'b0, 3'b111);
      tick(1);
      check_pins("brk_t9", 1'b1, 3'b111);

      // Sweep all eight addresses, one live change at a time.
      prev = 3'b111;
      for (int i = 0; i < 8; i++) begin
         set_addr(3'(i));
         tick(3);
         check_pins("sweep_open", 1'b0, prev);
         tick(1);
         check_pins("sweep_hold", 1'b0, prev);
         tick(1);
         check_pins("sweep_new", 1'b0, 3'(i));
         tick(3);
         check_pins("sweep_setup", 1'b0, 3'(i));
         tick(1);
         check_pins("sweep_on", 1'b1, 3'(i));
`ifdef BL_MUX_CH_STATUS_EN
         check("sweep_ch_active", ch_active, 8'd1 << i);
`endif
         prev = 3'(i);
      end

      // 5. Address change during SETUP restarts the setup interval.
      EN_in = 1'b0;
      tick(3);
      check_pins("to_idle", 1'b0, 3'b111);
      set_addr(3'b010);
      EN_in = 1'b1;
      tick(3);
      check_pins("setup_010", 1'b0, 3'b010);
      set_addr(3'b110);
      tick(2);
      check_pins("setup_pre_change", 1'b0, 3'b010);
      tick(1);
      check_pins("setup_110", 1'b0, 3'b110);
      tick(3);
      check_pins("setup_restart_t3", 1'b0, 3'b110);
      tick(1);
      check_pins("setup_restart_t4", 1'b1, 3'b110);

      // Enable drop and address change together: the drop wins.
      EN_in = 1'b0;
      set_addr(3'b001);
      tick(2);
      check_pins("simul_t2", 1'b1, 3'b110);
      tick(1);
      check_pins("simul_t3", 1'b0, 3'b110);
      tick(5);
      check_pins("simul_hold", 1'b0, 3'b110);

      // 6. Asynchronous reset while ON at 011.
      set_addr(3'b011);
      EN_in = 1'b1;
      tick(7);
      check_pins("on_011", 1'b1, 3'b011);
`ifdef BL_MUX_CH_STATUS_EN
      check("ch_active_011", ch_active, 8'b0000_1000);
`endif
      #2;
      Reset = 1'b0;
      #1;
      check_pins("async_reset", 1'b0, 3'b000);
`ifdef BL_MUX_CH_STATUS_EN
      check("async_reset_ch", ch_active, 8'd0);
`endif
      tick(2);
      Reset = 1'b1;
      EN_in = 1'b0;
      tick(4);
      check_pins("post_reset", 1'b0, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
